// File: rtl/sha1_stage_sequencer_if.sv
// Start/done handshake bundle between a chunk source and the SHA-1 stage sequencer.
interface sha1_stage_sequencer_if #(
  parameter int unsigned TAG_W = 2
);
  logic             start_valid;
  logic [TAG_W-1:0] start_tag;
  logic             start_ready;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;

  modport master (
    output start_valid, start_tag,
    input  start_ready, done_valid, done_tag
  );

  modport slave (
    input  start_valid, start_tag,
    output start_ready, done_valid, done_tag
  );
endinterface

// File: rtl/sha1_stage_sequencer.sv
// Dispatcher for an interleaved SHA-1 round pipeline: per-stage busy timers, load strobes,
// chunk tags and completion bookkeeping, with hand-offs deferred around the hash writeback cycle.
module sha1_stage_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ROUNDS     = 20,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  sha1_stage_sequencer_if.slave               bus,
  output logic [NUM_STAGES-1:0]               stage_load,
  output logic [NUM_STAGES-1:0]               stage_busy,
  output logic                                final_stage,
  output logic [$clog2(NUM_STAGES+1)-1:0]     in_flight,
  output logic [CNT_W-1:0]                    chunks_done,
  output logic                                overrun
);

  localparam int unsigned IF_W = $clog2(NUM_STAGES + 1);
  localparam int unsigned RC_W = $clog2(ROUNDS + 1);

  logic [RC_W-1:0]       cnt_q     [NUM_STAGES];
  logic [RC_W-1:0]       cnt_d     [NUM_STAGES];
  logic [TAG_W-1:0]      tag_q     [NUM_STAGES];
  logic [TAG_W-1:0]      tag_d     [NUM_STAGES];
  logic [NUM_STAGES-1:0] last_busy_q, last_busy_d;
  logic [NUM_STAGES-1:0] pend_q, pend_d;
  logic [TAG_W-1:0]      acc_tag_q, acc_tag_d;
  logic [IF_W-1:0]       in_flight_q, in_flight_d;
  logic [CNT_W-1:0]      chunks_done_q, chunks_done_d;
  logic                  overrun_q, overrun_d;

  logic [NUM_STAGES-1:0] fall_c;
  logic [NUM_STAGES-1:0] req_c;
  logic [NUM_STAGES-1:0] want_c;
  logic                  start_ready_c;
  logic                  accept_c;

  // Stage status, request collection and the writeback-collision deferral decision.
  always_comb begin
    stage_busy = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      stage_busy[s] = (cnt_q[s] != '0);
    end
    fall_c        = last_busy_q & ~stage_busy;
    final_stage   = fall_c[NUM_STAGES-1];
    start_ready_c = ~stage_busy[0] & ~pend_q[0];
    accept_c      = bus.start_valid & start_ready_c;
    req_c         = {fall_c[NUM_STAGES-2:0], accept_c};
    want_c        = req_c | pend_q;
  end

  assign stage_load      = final_stage ? '0 : want_c;
  assign bus.start_ready = start_ready_c;
  assign bus.done_valid  = final_stage;
  assign bus.done_tag    = tag_q[NUM_STAGES-1];
  assign in_flight       = in_flight_q;
  assign chunks_done     = chunks_done_q;
  assign overrun         = overrun_q;

  // Next-state for timers, tags and counters.
  always_comb begin
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    last_busy_d   = stage_busy;
    pend_d        = final_stage ? want_c : '0;
    acc_tag_d     = acc_tag_q;
    in_flight_d   = in_flight_q;
    chunks_done_d = chunks_done_q + CNT_W'(final_stage);
    overrun_d     = overrun_q | (|(stage_load & stage_busy));

    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (stage_load[s]) begin
        cnt_d[s] = RC_W'(ROUNDS);
      end else if (stage_busy[s]) begin
        cnt_d[s] = cnt_q[s] - RC_W'(1);
      end
    end

    if (accept_c) begin
      acc_tag_d = bus.start_tag;
    end
    if (stage_load[0]) begin
      tag_d[0] = accept_c ? bus.start_tag : acc_tag_q;
    end
    for (int s = 1; s < int'(NUM_STAGES); s++) begin
      if (stage_load[s]) begin
        tag_d[s] = tag_q[s-1];
      end
    end

    // Saturating occupancy; a simultaneous load and completion nets to zero.
    if (stage_load[0] && !final_stage) begin
      if (in_flight_q != IF_W'(NUM_STAGES)) begin
        in_flight_d = in_flight_q + IF_W'(1);
      end
    end else if (final_stage && !stage_load[0]) begin
      if (in_flight_q != '0) begin
        in_flight_d = in_flight_q - IF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(NUM_STAGES); s++) begin
        cnt_q[s] <= '0;
        tag_q[s] <= '0;
      end
      last_busy_q   <= '0;
      pend_q        <= '0;
      acc_tag_q     <= '0;
      in_flight_q   <= '0;
      chunks_done_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tag_q         <= tag_d;
      last_busy_q   <= last_busy_d;
      pend_q        <= pend_d;
      acc_tag_q     <= acc_tag_d;
      in_flight_q   <= in_flight_d;
      chunks_done_q <= chunks_done_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sha1_stage_sequencer.sv
// Scoreboard bench for sha1_stage_sequencer: timestamp-based reference model plus done monitor.
module tb_sha1_stage_sequencer;
  localparam int unsigned NS = 4;
  localparam int unsigned RN = 20;
  localparam int unsigned TW = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] stage_load, stage_busy;
  logic          final_stage;
  logic [IW-1:0] in_flight;
  logic [CW-1:0] chunks_done;
  logic          overrun;

  always #5 clk = ~clk;

  sha1_stage_sequencer_if #(.TAG_W(TW)) bus ();

  sha1_stage_sequencer #(.NUM_STAGES(NS), .ROUNDS(RN), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stage_load(stage_load), .stage_busy(stage_busy), .final_stage(final_stage),
    .in_flight(in_flight), .chunks_done(chunks_done), .overrun(overrun)
  );

  typedef struct { int cyc; logic [TW-1:0] tag; } done_t;
  done_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int last_done_cyc = -1;

  // Reference model: each stage is described by the absolute cycle of its last busy cycle.
  int            busy_until[NS];
  logic [TW-1:0] m_tag[NS];
  logic [TW-1:0] m_acc_tag;
  logic [NS-1:0] m_pend;
  int            m_inflight;
  int            m_chunks;
  bit            m_overrun;
  bit            m_accepted;
  bit            force_on = 1'b0;
  logic [NS-1:0] force_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < int'(NS); s++) begin
      busy_until[s] = -1000;
      m_tag[s] = '0;
    end
    m_acc_tag = '0; m_pend = '0; m_inflight = 0; m_chunks = 0; m_overrun = 0; m_accepted = 0;
  endtask

  task automatic model_step();
    logic [NS-1:0] busy, fall, req, want, load;
    bit fin, rdy, acc;
    for (int s = 0; s < int'(NS); s++) begin
      busy[s] = (cyc <= busy_until[s]);
      fall[s] = (cyc == busy_until[s] + 1);
    end
    fin = fall[NS-1];
    rdy = !busy[0] && !m_pend[0];
    acc = bus.start_valid && rdy;
    for (int s = 0; s < int'(NS); s++) req[s] = (s == 0) ? acc : fall[s-1];
    want = req | m_pend;
    load = fin ? '0 : want;
    if (force_on) load = force_mask;

    check("start_ready", 32'(bus.start_ready), 32'(rdy));
    check("stage_load",  32'(stage_load),      32'(load));
    check("stage_busy",  32'(stage_busy),      32'(busy));
    check("final_stage", 32'(final_stage),     32'(fin));
    check("done_valid",  32'(bus.done_valid),  32'(fin));
    check("in_flight",   32'(in_flight),       32'(m_inflight));
    check("chunks_done", 32'(chunks_done),     32'(m_chunks));
    check("overrun",     32'(overrun),         32'(m_overrun));

    if (fin) exp_q.push_back('{cyc, m_tag[NS-1]});

    for (int s = int'(NS) - 1; s >= 1; s--) if (load[s]) m_tag[s] = m_tag[s-1];
    if (load[0]) m_tag[0] = acc ? bus.start_tag : m_acc_tag;
    if (acc) m_acc_tag = bus.start_tag;
    for (int s = 0; s < int'(NS); s++) begin
      if (load[s]) begin
        if (busy[s]) m_overrun = 1;
        busy_until[s] = cyc + int'(RN);
      end
    end
    m_pend = fin ? want : '0;
    if (load[0] && !fin) m_inflight = (m_inflight < int'(NS)) ? m_inflight + 1 : m_inflight;
    else if (fin && !load[0]) m_inflight = (m_inflight > 0) ? m_inflight - 1 : 0;
    if (fin) m_chunks = (m_chunks + 1) % (1 << CW);
    m_accepted = acc;
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    else model_step();
    cyc++;
  end

  // Done monitor: pops the scoreboard whenever the DUT presents a completion.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.done_valid === 1'b1) begin
        n_done++;
        last_done_cyc = cyc - 1;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc - 1), 32'(e.cyc));
          check("done_tag", 32'(bus.done_tag), 32'(e.tag));
        end
      end
    end
  end

  task automatic tick(input bit v, input logic [TW-1:0] t, input bit r);
    @(posedge clk);
    #1;
    if (force_on) begin
      release dut.stage_load;
      force_on = 1'b0;
    end
    bus.start_valid = v;
    bus.start_tag = t;
    reset = r;
    @(negedge clk);
    #2;
  endtask

  task automatic tick_force(input logic [NS-1:0] m);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    reset = 1'b0;
    force dut.stage_load = m;
    force_mask = m;
    force_on = 1'b1;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d0;
    logic [TW-1:0] tags [4];
    bit got;
    bus.start_valid = 1'b0;
    bus.start_tag = '0;
    repeat (3) tick(1'b0, '0, 1'b1);

    // Single chunk end to end.
    tick(1'b1, 2'd2, 1'b0);
    t0 = cyc - 1;
    idle(100);
    check("single_latency", 32'(last_done_cyc - t0), 32'(NS * (RN + 1)));

    // Four back-to-back chunks filling every stage.
    tags[0] = 2'd1; tags[1] = 2'd2; tags[2] = 2'd3; tags[3] = 2'd0;
    d0 = n_done;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, tags[k], 1'b0);
      idle(20);
    end
    idle(100);
    check("four_chunks", 32'(n_done - d0), 32'd4);

    // Second start offered exactly on the writeback cycle is deferred by one.
    tick(1'b1, 2'd1, 1'b0);
    t0 = cyc - 1;
    idle(83);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(1'b1, 2'd2, 1'b0);
      got = m_accepted;
    end
    idle(100);
    check("deferred_done", 32'(last_done_cyc - t0), 32'd169);

    // Reset mid-flight aborts the chunk; a fresh one completes normally.
    tick(1'b1, 2'd3, 1'b0);
    t0 = cyc - 1;
    idle(29);
    tick(1'b0, '0, 1'b1);
    idle(9);
    tick(1'b1, 2'd1, 1'b0);
    idle(100);
    check("after_reset_done", 32'(last_done_cyc - t0), 32'd124);

    // Completed-chunk counter wraps after 256 completions.
    tick(1'b0, '0, 1'b1);
    n_done = 0;
    for (int i = 0; i < 12000 && n_done < 256; i++) tick(1'b1, TW'($urandom), 1'b0);
    check("wrap_reached", 32'(n_done), 32'd256);
    tick(1'b0, '0, 1'b0);
    check("wrap_zero", 32'(chunks_done), 32'd0);
    idle(100);

    // Load forced onto a busy stage sets the sticky overrun flag.
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 2'd3, 1'b0);
    idle(25);
    tick_force(4'b0010);
    idle(2);
    check("overrun_set", 32'(overrun), 32'd1);
    idle(120);
    check("overrun_sticky", 32'(overrun), 32'd1);
    tick(1'b0, '0, 1'b1);
    idle(2);
    check("overrun_clear", 32'(overrun), 32'd0);

    // Randomised traffic with occasional resets.
    repeat (3000) tick(($urandom_range(0, 3) != 0), TW'($urandom), ($urandom_range(0, 499) == 0));
    idle(120);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
